// File: rtl/multiword_add_ctrl.sv
// Nibble-serial add/subtract unit: one shared 4-bit ripple slice walks WIDTH-bit
// operands LSB nibble first, linked by a carry register, with a start/done handshake.
module multiword_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCH  = WIDTH / 4;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic [4:0]       w_slice;
  logic             w_last;

  // The shared slice: op_b already holds ~b in subtract mode, so a carry-in of 1 completes a-b.
  assign w_nib_a = r_op_a[{r_idx, 2'b00} +: 4];
  assign w_nib_b = r_op_b[{r_idx, 2'b00} +: 4];
  assign w_slice = {1'b0, w_nib_a} + {1'b0, w_nib_b} + {4'b0000, r_carry};
  assign w_last  = (r_idx == IDXW'(NCH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_slice[3:0];
          r_carry <= w_slice[4];
          r_idx   <= r_idx + IDXW'(1);
          // Top nibble: the slice carry is the final carry and its bit 3 is the result sign.
          if (w_last) begin
            r_cout  <= w_slice[4];
            r_ovf   <= (r_op_a[WIDTH-1] == r_op_b[WIDTH-1]) &&
                       (w_slice[3] != r_op_a[WIDTH-1]);
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed self-checking bench for multiword_add_ctrl at WIDTH=16 with hand-computed results.
module tb_multiword_add_ctrl;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  int testsRun;
  int testsFailed;

  multiword_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Launch one operation with a single-cycle start, then wait (bounded) for done.
  task automatic applyStimulus(input string tag, input logic [15:0] opA, input logic [15:0] opB,
                               input logic opSub, input logic opCin,
                               input logic [15:0] expSum, input logic expCout,
                               input logic expOvf);
    int cycles;
    int busyCycles;
    @(negedge clk);
    a = opA; b = opB; sub = opSub; cin = opCin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = ~opCin;
    cycles = 0;
    busyCycles = 0;
    while (!done && cycles < 20) begin
      if (busy) busyCycles++;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, " latency"}, cycles, 4);
    checkOutput({tag, " busy cycles"}, busyCycles, 4);
    checkOutput({tag, " done"}, {31'd0, done}, 1);
    checkOutput({tag, " sum"}, {16'd0, sum}, {16'd0, expSum});
    checkOutput({tag, " cout"}, {31'd0, cout}, {31'd0, expCout});
    checkOutput({tag, " overflow"}, {31'd0, overflow}, {31'd0, expOvf});
    @(posedge clk); #1;
    checkOutput({tag, " done pulse width"}, {31'd0, done}, 0);
    checkOutput({tag, " sum held"}, {16'd0, sum}, {16'd0, expSum});
  endtask

  initial begin
    int cycles;
    int doneCount;
    testsRun = 0;
    testsFailed = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", {31'd0, busy}, 0);
    checkOutput("reset done", {31'd0, done}, 0);
    checkOutput("reset sum", {16'd0, sum}, 0);
    checkOutput("reset cout", {31'd0, cout}, 0);
    checkOutput("reset overflow", {31'd0, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus("add FFFF+1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus("add 7FFF+0+cin", 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    applyStimulus("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    applyStimulus("sub 5-7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    applyStimulus("sub 8000-1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Reset during the second RUN cycle; cout/overflow are still 1 from the previous op.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("partial nibble 0", {16'd0, sum}, 32'h7FF3);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, busy}, 0);
    checkOutput("abort done", {31'd0, done}, 0);
    checkOutput("abort sum", {16'd0, sum}, 0);
    checkOutput("abort cout", {31'd0, cout}, 0);
    checkOutput("abort overflow", {31'd0, overflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) doneCount++;
    end
    checkOutput("abort no done", doneCount, 0);
    applyStimulus("post-reset 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Start pulses with other operands while running must not disturb the result.
    @(negedge clk);
    a = 16'h0100; b = 16'h0011; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h4444; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("ignore done", {31'd0, done}, 1);
    checkOutput("ignore sum", {16'd0, sum}, 32'h0111);
    checkOutput("ignore cout", {31'd0, cout}, 0);
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) doneCount++;
    end
    checkOutput("ignore extra done", doneCount, 0);

    // Back-to-back: start held through DONE with fresh operands.
    @(negedge clk);
    a = 16'h0003; b = 16'h0004; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    cycles = 0;
    while (!done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("b2b first latency", cycles, 4);
    checkOutput("b2b first sum", {16'd0, sum}, 32'h0007);
    a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b no idle", {31'd0, busy}, 1);
    cycles = 0;
    while (!done && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("b2b done gap", cycles + 1, 5);
    checkOutput("b2b second sum", {16'd0, sum}, 32'h0002);
    checkOutput("b2b second cout", {31'd0, cout}, 0);
    checkOutput("b2b second overflow", {31'd0, overflow}, 0);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
